seq_divider_16by8: RTL

- Iterative restoring divider: 2*DW-bit unsigned dividend ÷ DW-bit unsigned divisor → DW-bit quotient + DW-bit remainder.
- Inverse partner of the 8x8→16 multiplier datapath; used to normalise the regression accumulator sums (e.g. slope = Sxy/Sxx).
- Produces one quotient bit per clock and uses a start/busy/done handshake.

---
 rtl/seq_divider_16by8.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seq_divider_16by8.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seq_divider_16by8 : iterative restoring divider, 2*DW / DW -> DW quotient and
//                     remainder, one quotient bit per clock, start/busy/done.
//                     Optional round-to-nearest stage: define DIV_ROUND_EN.
// Revision: 1.0
// -----------------------------------------------------------------------------
module seq_divider_16by8 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int              CW       = $clog2(DW + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(DW);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
`ifdef DIV_ROUND_EN
    ROUND = 2'd3,
`endif
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   shl_q, shl_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DW-1:0]   quotient_q, quotient_d;
  logic [DW-1:0]   remainder_q, remainder_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic [DW-1:0]   dividend_hi;
  logic [DW-1:0]   dividend_lo;
  logic [DW:0]     trial;
  logic            trial_ge;
  logic [DW-1:0]   rem_next;
  logic [DW-1:0]   quo_next;

  assign dividend_hi = dividend[2*DW-1:DW];
  assign dividend_lo = dividend[DW-1:0];

  // One restoring step; compare and subtract are DW+1 bits so nothing wraps.
  assign trial    = {rem_q, shl_q[DW-1]};
  assign trial_ge = (trial >= {1'b0, dvs_q});
  assign rem_next = DW'(trial_ge ? (trial - {1'b0, dvs_q}) : trial);
  assign quo_next = {quo_q[DW-2:0], trial_ge};

`ifdef DIV_ROUND_EN
  logic            round_up;
  logic [DW-1:0]   quo_rounded;

  assign round_up    = ({rem_q, 1'b0} >= {1'b0, dvs_q});
  assign quo_rounded = (round_up && !(&quo_q)) ? (quo_q + DW'(1)) : quo_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      shl_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      shl_q       <= shl_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    shl_d       = shl_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend_lo;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            state_d     = DONE;
          end else if (dividend_hi >= divisor) begin
            // Upper half already >= divisor: the quotient needs more than DW bits.
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = dividend_hi;
            shl_d   = dividend_lo;
            quo_d   = '0;
            dvs_d   = divisor;
            cnt_d   = CNT_INIT;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = rem_next;
        shl_d = {shl_q[DW-2:0], 1'b0};
        quo_d = quo_next;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
`ifdef DIV_ROUND_EN
          state_d     = ROUND;
`else
          quotient_d  = quo_next;
          remainder_d = rem_next;
          state_d     = DONE;
`endif
        end
      end

`ifdef DIV_ROUND_EN
      ROUND: begin
        quotient_d  = quo_rounded;
        remainder_d = rem_q;
        state_d     = DONE;
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
`ifdef DIV_ROUND_EN
    busy = busy || (state_q == ROUND);
`endif
  end

  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire
